decode_queue_multilane: RTL
===========================

Name: decode_queue_multilane

Overview:
- Next-generation front-end decode stage. Accepts a fetch bundle of up to LANES instructions per cycle, each with its own valid bit.
- Classifies each valid instruction by primary opcode into its format class. Compacts valid lanes in order into a circular decode queue.
- Issues one classified instruction per cycle downstream under a valid/ready handshake.
- Sits between the fetch unit and the per-format field decoders. Decouples fetch bandwidth from decode bandwidth and supports pipeline flush.

Parameters:
- instructionWidth, 32, instruction bits
- addressSize, 64, instruction address bits
- opcodeWidth, 6, primary opcode bits (instruction bits 0..5)
- formatIndexRange, 5, format class index width
- LANES, 4, instruction slots per fetch bundle (1..8)
- DEPTH, 8, queue entries; power of two, DEPTH >= LANES
- Format class codes: INVALID=0, B=2, D=3, DS=5, I=7, MD=9, SC=11, X=15, XL=18

Ports:
- clock_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- enable_i  in  1  global enable; low freezes all state
- flush_i  in  1  discard all queued entries
- bundleValid_i  in  1  bundle offered
- laneValid_i  in  LANES  per-lane valid, bit 0 = lane 0 = oldest
- instruction_i  in  LANES*instructionWidth  lane k occupies slice k
- instructionAddress_i  in  addressSize  address of lane 0
- bundleReady_o  out  1  queue can take a full bundle
- ready_i  in  1  downstream accepts
- valid_o  out  1  head entry valid
- opCode_o  out  opcodeWidth  head opcode
- payload_o  out  instructionWidth-opcodeWidth  head bits 6..31
- address_o  out  addressSize  head address
- instructionFormatClass_o  out  formatIndexRange  head class
- occupancy_o  out  log2(DEPTH)+1  registered entry count

Behaviour:
- Reset (synchronous, high): head, tail and count are cleared to 0. valid_o=0, occupancy_o=0, bundleReady_o=1. Queue payload contents are don't-care.
- enable_i=0: no enqueue, no dequeue, no flush. All registers hold.
- bundleReady_o = (count <= DEPTH-LANES), computed from registered count only. A same-cycle dequeue does not raise it.
- Enqueue when enable_i & bundleValid_i & bundleReady_o & !flush_i:
  - Write popcount(laneValid_i) entries at tail, in ascending lane order, skipping invalid lanes.
  - Tail advances by that popcount, modulo DEPTH.
  - A bundle with laneValid_i=0 is accepted and writes nothing.
- Per-entry address = instructionAddress_i + 4*k, where k is the source lane index (not the compacted position). Wraps modulo 2^addressSize.
- Classification is done at enqueue and stored per entry. Class by opcode:
  - 18 → I
  - 16 → B
  - 19 → XL
  - 17 → SC
  - 7, 8, 10–15, 24–29, 32–47 → D
  - 31 → X
  - 30 → MD
  - 58, 62 → DS
  - any other → INVALID
- INVALID entries are still queued and issued, so downstream can raise a program exception.
- valid_o = (count != 0). All output fields are driven combinationally from the head entry. Fields are don't-care while valid_o=0.
- Dequeue when enable_i & valid_o & ready_i & !flush_i: head advances by 1, modulo DEPTH.
- Latency: an instruction enqueued at edge t is visible on valid_o in cycle t+1, provided it is at the head.
- Enqueue and dequeue may occur in the same cycle: count_next = count + popcount − dequeue.
- flush_i=1 (with enable_i=1): head=tail=count=0 at the next edge. A simultaneous bundle and dequeue are both ignored, so flush wins. valid_o=0 in the following cycle.
- Reset asserted mid-stream: queue is emptied identically to flush, regardless of enable_i.
- Output fields are held stable while valid_o=1 and ready_i=0.
- Queue never over- or under-flows. No overflow error path exists, because bundleReady_o guarantees space for LANES entries.

Test Plan:
- Reset, then bundle lanes 0..3 = 0x48000010, 0x7C221A14, 0x38600001, 0x40820008 at address 0x1000, mask 4'b1111, ready_i=1. Required: four consecutive valid_o cycles, classes 7, 15, 3, 2, addresses 0x1000, 0x1004, 0x1008, 0x100C.
- Mask 4'b1010, lane1 = 0x44000002, lane3 = 0xE8010008, address 0x2000. Required: two entries, class 11 @0x2004, then class 5 @0x200C; occupancy_o peaks at 2.
- ready_i=0 with full bundles each cycle, DEPTH=8, LANES=4. Required: occupancy_o goes 4 → 8; bundleReady_o=0 at 8; third bundle is not accepted. Then a single ready_i pulse gives occupancy 7, bundleReady_o stays 0.
- Occupancy 6 with a bundle, dequeue and flush_i all in one cycle. Required: next cycle occupancy_o=0, valid_o=0. The following bundle is accepted normally.
- Address 0xFFFFFFFFFFFFFFF8 with mask 4'b1111. Required: addresses ...FFF8, ...FFFC, 0x0, 0x4.
- Opcode 1 (0x04000000). Required: entry issued with class 0 (INVALID). enable_i=0 for 3 cycles mid-stream holds occupancy_o and all head outputs unchanged.

Source files
------------

// File: rtl/decode_queue_multilane.sv
// Multi-lane decode queue: compacts valid fetch lanes into a circular buffer,
// classifies each entry by primary opcode and issues one entry per cycle.
module decode_queue_multilane #(
  parameter int unsigned instructionWidth = 32,
  parameter int unsigned addressSize      = 64,
  parameter int unsigned opcodeWidth      = 6,
  parameter int unsigned formatIndexRange = 5,
  parameter int unsigned LANES            = 4,
  parameter int unsigned DEPTH            = 8
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic                                enable_i,
  input  logic                                flush_i,
  input  logic                                bundleValid_i,
  input  logic [LANES-1:0]                    laneValid_i,
  input  logic [LANES*instructionWidth-1:0]   instruction_i,
  input  logic [addressSize-1:0]              instructionAddress_i,
  output logic                                bundleReady_o,
  input  logic                                ready_i,
  output logic                                valid_o,
  output logic [opcodeWidth-1:0]              opCode_o,
  output logic [instructionWidth-opcodeWidth-1:0] payload_o,
  output logic [addressSize-1:0]              address_o,
  output logic [formatIndexRange-1:0]         instructionFormatClass_o,
  output logic [$clog2(DEPTH):0]              occupancy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PAY_W = instructionWidth - opcodeWidth;

  localparam logic [formatIndexRange-1:0] CLS_INVALID = formatIndexRange'(0);
  localparam logic [formatIndexRange-1:0] CLS_B       = formatIndexRange'(2);
  localparam logic [formatIndexRange-1:0] CLS_D       = formatIndexRange'(3);
  localparam logic [formatIndexRange-1:0] CLS_DS      = formatIndexRange'(5);
  localparam logic [formatIndexRange-1:0] CLS_I       = formatIndexRange'(7);
  localparam logic [formatIndexRange-1:0] CLS_MD      = formatIndexRange'(9);
  localparam logic [formatIndexRange-1:0] CLS_SC      = formatIndexRange'(11);
  localparam logic [formatIndexRange-1:0] CLS_X       = formatIndexRange'(15);
  localparam logic [formatIndexRange-1:0] CLS_XL      = formatIndexRange'(18);

  // Opcode sits in the most-significant bits (big-endian bit 0 = MSB).
  function automatic logic [formatIndexRange-1:0] classify(input logic [opcodeWidth-1:0] op);
    logic [formatIndexRange-1:0] cls;
    cls = CLS_INVALID;
    case (32'(op)) inside
      32'd18:                                      cls = CLS_I;
      32'd16:                                      cls = CLS_B;
      32'd19:                                      cls = CLS_XL;
      32'd17:                                      cls = CLS_SC;
      32'd7, 32'd8, [32'd10:32'd15], [32'd24:32'd29], [32'd32:32'd47]:
                                                   cls = CLS_D;
      32'd31:                                      cls = CLS_X;
      32'd30:                                      cls = CLS_MD;
      32'd58, 32'd62:                              cls = CLS_DS;
      default:                                     cls = CLS_INVALID;
    endcase
    return cls;
  endfunction

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [opcodeWidth-1:0]      opc_q  [DEPTH];
  logic [PAY_W-1:0]            pay_q  [DEPTH];
  logic [addressSize-1:0]      addr_q [DEPTH];
  logic [formatIndexRange-1:0] cls_q  [DEPTH];

  logic [CNT_W-1:0] pop_c;
  logic [PTR_W-1:0] wr_idx_c [LANES];
  logic             enq_c;
  logic             deq_c;

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      wr_idx_c[k] = tail_q + PTR_W'(acc);
      acc = acc + CNT_W'(laneValid_i[k]);
    end
    pop_c = acc;
  end

  assign bundleReady_o = (count_q <= CNT_W'(DEPTH - LANES));
  assign valid_o       = (count_q != '0);
  assign enq_c = enable_i & bundleValid_i & bundleReady_o & ~flush_i;
  assign deq_c = enable_i & valid_o & ready_i & ~flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enable_i && flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_c) begin
        tail_d  = tail_q + PTR_W'(pop_c);
        count_d = count_d + pop_c;
      end
      if (deq_c) begin
        head_d  = head_q + PTR_W'(1);
        count_d = count_d - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock_i) begin
    if (enq_c) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (laneValid_i[k]) begin
          opc_q[wr_idx_c[k]]  <= instruction_i[k*instructionWidth + PAY_W +: opcodeWidth];
          pay_q[wr_idx_c[k]]  <= instruction_i[k*instructionWidth +: PAY_W];
          addr_q[wr_idx_c[k]] <= instructionAddress_i + addressSize'(4 * k);
          cls_q[wr_idx_c[k]]  <= classify(instruction_i[k*instructionWidth + PAY_W +: opcodeWidth]);
        end
      end
    end
  end

  assign opCode_o                 = opc_q[head_q];
  assign payload_o                = pay_q[head_q];
  assign address_o                = addr_q[head_q];
  assign instructionFormatClass_o = cls_q[head_q];
  assign occupancy_o              = count_q;

endmodule
